// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and constants for the clock divider and its ratio meter
package clk_div_pkg;
  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} meter_state_t;
  localparam int MIN_RATIO = 2;
  function automatic int arm_window(input int width);
    return 2 ** (width + 1);
  endfunction
endpackage

// File: rtl/edge_sync.sv
// edge_sync: synchronises an asynchronous level and flags its rising and falling edges
module edge_sync #(
  parameter int STAGES = 2
)(
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic              s_d_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q[0] <= d_i;
      for (int k = 1; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
      s_d_q <= sync_q[STAGES-1];
    end
  end
  assign rise_o = sync_q[STAGES-1] & ~s_d_q;
  assign fall_o = ~sync_q[STAGES-1] & s_d_q;
endmodule

// File: rtl/clk_ratio_meter.sv
// clk_ratio_meter: measures high/low/period of a divided clock in reference cycles,
// with lock detection, expected-ratio mismatch and timeout reporting
module clk_ratio_meter
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 3
)(
  input  logic             i_clk_ref,
  input  logic             i_rst,
  input  logic             i_meas_en,
  input  logic             i_div_clk,
  input  logic [WIDTH-1:0] i_exp_ratio,
  output logic [WIDTH-1:0] o_ratio,
  output logic [WIDTH-1:0] o_high_cnt,
  output logic [WIDTH-1:0] o_low_cnt,
  output logic             o_valid,
  output logic             o_locked,
  output logic             o_mismatch,
  output logic             o_timeout
);
  localparam int               MW       = $clog2(LOCK_COUNT + 1);
  localparam int               AW       = arm_window(WIDTH);
  localparam logic [WIDTH:0]   LIM      = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0]   ARM_LAST = (WIDTH+1)'(AW - 1);
  localparam logic [WIDTH:0]   MIN_P    = (WIDTH+1)'(MIN_RATIO);
  localparam logic [WIDTH:0]   ONE      = (WIDTH+1)'(1);
  localparam logic [MW-1:0]    LC       = MW'(LOCK_COUNT);
  meter_state_t     state_q, state_d;
  logic [WIDTH:0]   cnt_q, cnt_d, arm_q, arm_d, cnt_inc, hsum;
  logic [WIDTH-1:0] high_q, high_d, ratio_q, ratio_d, hcnt_q, hcnt_d, lcnt_q, lcnt_d;
  logic [MW-1:0]    match_q, match_d, match_nx;
  logic             valid_q, valid_d, locked_q, locked_d, timeout_q, timeout_d;
  logic             have_q, have_d, tmo, rise, fall;
  edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (i_clk_ref),
    .rst    (i_rst),
    .d_i    (i_div_clk),
    .rise_o (rise),
    .fall_o (fall)
  );
  assign cnt_inc  = cnt_q + ONE;
  assign hsum     = {1'b0, high_q} + cnt_q;
  assign match_nx = (have_q && hsum[WIDTH-1:0] == ratio_q) ? (match_q == LC ? LC : match_q + MW'(1)) : MW'(1);
  // Any missing edge lands in tmo, which overrides the per-state next values below
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    arm_d     = arm_q;
    high_d    = high_q;
    ratio_d   = ratio_q;
    hcnt_d    = hcnt_q;
    lcnt_d    = lcnt_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;
    match_d   = match_q;
    have_d    = have_q;
    tmo       = 1'b0;
    if (!i_meas_en) begin
      state_d  = IDLE;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = ARM;
          timeout_d = 1'b0;
          locked_d  = 1'b0;
          arm_d     = '0;
          match_d   = '0;
          have_d    = 1'b0;
        end
        ARM: begin
          if (rise) begin
            state_d = HIGH;
            cnt_d   = ONE;
          end else if (arm_q == ARM_LAST) tmo = 1'b1;
          else arm_d = arm_q + ONE;
        end
        HIGH: begin
          if (fall) begin
            state_d = LOW;
            high_d  = cnt_q[WIDTH-1:0];
            cnt_d   = ONE;
          end else if (cnt_inc >= LIM) tmo = 1'b1;
          else cnt_d = cnt_inc;
        end
        LOW: begin
          if (rise) begin
            if (hsum >= LIM || hsum < MIN_P) tmo = 1'b1;
            else begin
              state_d  = HIGH;
              cnt_d    = ONE;
              valid_d  = 1'b1;
              ratio_d  = hsum[WIDTH-1:0];
              hcnt_d   = high_q;
              lcnt_d   = cnt_q[WIDTH-1:0];
              match_d  = match_nx;
              have_d   = 1'b1;
              locked_d = (match_nx == LC);
            end
          end else if (hsum + ONE >= LIM) tmo = 1'b1;
          else cnt_d = cnt_inc;
        end
        default: state_d = IDLE;
      endcase
    end
    if (tmo) begin
      state_d   = ARM;
      timeout_d = 1'b1;
      locked_d  = 1'b0;
      arm_d     = '0;
      match_d   = '0;
      have_d    = 1'b0;
    end
  end
  always_ff @(posedge i_clk_ref) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      arm_q     <= '0;
      high_q    <= '0;
      ratio_q   <= '0;
      hcnt_q    <= '0;
      lcnt_q    <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
      match_q   <= '0;
      have_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      arm_q     <= arm_d;
      high_q    <= high_d;
      ratio_q   <= ratio_d;
      hcnt_q    <= hcnt_d;
      lcnt_q    <= lcnt_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
      match_q   <= match_d;
      have_q    <= have_d;
    end
  end
  assign o_ratio    = ratio_q;
  assign o_high_cnt = hcnt_q;
  assign o_low_cnt  = lcnt_q;
  assign o_valid    = valid_q;
  assign o_locked   = locked_q;
  assign o_timeout  = timeout_q;
  assign o_mismatch = valid_q && i_exp_ratio != '0 && ratio_q != i_exp_ratio;
endmodule

// File: tb/tb_clk_ratio_meter.sv
// tb_clk_ratio_meter: directed + randomized check of clk_ratio_meter against a period-level model
module tb_clk_ratio_meter;
  localparam int W = 4, SS = 2, LC = 3, LAT = SS + 1, HN = 4096;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, div = 1'b0;
  logic [W-1:0] exp_r = '0;
  logic [W-1:0] ratio, hcnt, lcnt;
  logic valid, locked, mism, tmo;
  int tests = 0, fails = 0, cyc = 0, n_valid = 0;
  int ph = 0, n_cur = 4, h_cur = 2, n_nxt = 4, h_nxt = 2, mode = 0;
  int run = 0, prev_n = 0, last_vc = -1;
  bit have_prev = 1'b0, chk_to = 1'b0;
  int hist_n[HN], hist_h[HN];

  clk_ratio_meter #(.WIDTH(W), .SYNC_STAGES(SS), .LOCK_COUNT(LC)) dut (
    .i_clk_ref   (clk),
    .i_rst       (rst),
    .i_meas_en   (en),
    .i_div_clk   (div),
    .i_exp_ratio (exp_r),
    .o_ratio     (ratio),
    .o_high_cnt  (hcnt),
    .o_low_cnt   (lcnt),
    .o_valid     (valid),
    .o_locked    (locked),
    .o_mismatch  (mism),
    .o_timeout   (tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic model_reset();
    run = 0;
    have_prev = 1'b0;
    last_vc = -1;
  endtask

  task automatic set_ratio(input int n);
    n_nxt = n;
    h_nxt = (n % 2 == 1 && $urandom_range(0, 1) == 1) ? n / 2 : n - n / 2;
  endtask

  task automatic start_div();
    mode = 2;
    n_cur = n_nxt;
    h_cur = h_nxt;
    ph = n_cur - 1;
  endtask

  // Each o_valid reports the divider period that ended LAT cycles earlier
  task automatic check_cycle();
    int k, n, h;
    if (mode != 2) chk("no_valid", valid, 0);
    if (valid) begin
      k = (cyc - LAT) % HN;
      n = hist_n[k];
      h = hist_h[k];
      n_valid++;
      chk("ratio", ratio, n);
      chk("high", hcnt, h);
      chk("low", lcnt, n - h);
      chk("mismatch", mism, (exp_r != 0 && n != int'(exp_r)));
      if (last_vc >= 0) chk("gap", cyc - last_vc, n);
      last_vc = cyc;
      run = (have_prev && n == prev_n) ? run + 1 : 1;
      prev_n = n;
      have_prev = 1'b1;
      chk("locked", locked, run >= LC);
      if (chk_to) chk("no_timeout", tmo, 0);
    end else chk("mismatch_idle", mism, 0);
  endtask

  task automatic tick();
    int k;
    @(posedge clk);
    #1;
    cyc++;
    k = cyc % HN;
    hist_n[k] = 0;
    hist_h[k] = 0;
    if (mode == 2) begin
      ph++;
      if (ph >= n_cur) begin
        hist_n[k] = n_cur;
        hist_h[k] = h_cur;
        n_cur = n_nxt;
        h_cur = h_nxt;
        ph = 0;
      end
      div = (ph < h_cur);
    end else div = (mode == 1);
    @(negedge clk);
    check_cycle();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ratio"}, ratio, 0);
    chk({tag, "_high"}, hcnt, 0);
    chk({tag, "_low"}, lcnt, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_mismatch"}, mism, 0);
    chk({tag, "_timeout"}, tmo, 0);
  endtask

  initial begin
    int w;
    for (int i = 0; i < HN; i++) begin
      hist_n[i] = 0;
      hist_h[i] = 0;
    end
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    // ratio 4, expected 4
    exp_r = 4;
    set_ratio(4);
    start_div();
    repeat (10) tick();
    en = 1'b1;
    model_reset();
    chk_to = 1'b1;
    n_valid = 0;
    repeat (40) tick();
    chk("t1_count", n_valid >= 7, 1);
    chk("t1_locked", locked, 1);
    // odd ratio and the largest measurable ratio
    exp_r = 0;
    set_ratio(5);
    repeat (60) tick();
    chk("t2_locked5", locked, 1);
    set_ratio(15);
    repeat (100) tick();
    chk("t2_locked15", locked, 1);
    chk("t2_timeout", tmo, 0);
    // ratio switch while locked
    set_ratio(6);
    repeat (40) tick();
    chk("t4_locked6", locked, 1);
    set_ratio(3);
    repeat (30) tick();
    chk("t4_locked3", locked, 1);
    // mismatch against expected 7, then disabled check
    set_ratio(6);
    exp_r = 7;
    repeat (40) tick();
    exp_r = 0;
    repeat (40) tick();
    // randomized ratios, expected values and enable gaps
    for (int i = 0; i < 6; i++) begin
      int n;
      n = $urandom_range(2, 15);
      en = 1'b0;
      tick();
      chk("dis_locked", locked, 0);
      repeat ($urandom_range(0, 6)) tick();
      set_ratio(n);
      exp_r = ($urandom_range(0, 2) == 0) ? '0 : (($urandom_range(0, 1) == 1) ? W'(n) : W'($urandom_range(1, 15)));
      en = 1'b1;
      model_reset();
      repeat (6 * n + 40) tick();
      chk("rand_locked", locked, 1);
    end
    // reset in the low phase
    exp_r = 10;
    set_ratio(10);
    w = 0;
    while (!(n_cur == 10 && ph == 8) && w < 100) begin
      tick();
      w++;
    end
    chk("t6_reach_low", w < 100, 1);
    rst = 1'b1;
    tick();
    chk_zero("t6_rst");
    rst = 1'b0;
    model_reset();
    n_valid = 0;
    repeat (60) tick();
    chk("t6_valids", n_valid >= 3, 1);
    chk("t6_locked", locked, 1);
    // constant-low divider (ratio 0)
    en = 1'b0;
    tick();
    mode = 0;
    chk_to = 1'b0;
    repeat (5) tick();
    en = 1'b1;
    model_reset();
    repeat (20) tick();
    chk("t3_to_early", tmo, 0);
    repeat (20) tick();
    chk("t3_to0", tmo, 1);
    chk("t3_locked0", locked, 0);
    en = 1'b0;
    tick();
    chk("t3_to_hold", tmo, 1);
    chk("t3_locked_off", locked, 0);
    // constant-high divider (ratio 1 in the reference domain)
    mode = 1;
    repeat (5) tick();
    en = 1'b1;
    tick();
    tick();
    chk("t3_to_clear", tmo, 0);
    repeat (40) tick();
    chk("t3_to1", tmo, 1);
    chk("t3_locked1", locked, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
